// File: rtl/power_button_wbm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : power_button_wbm_pkg
// Description : Command codes, master FSM states and power_manager register
//               defaults shared by power_button_wbm and power_manager.
// Revision    : 1.0 - initial release
// ============================================================================
package power_button_wbm_pkg;

    typedef enum logic [1:0] {
        CMD_NONE     = 2'd0,
        CMD_POWERUP  = 2'd1,
        CMD_RESTART  = 2'd2,
        CMD_SHUTDOWN = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_REQ  = 2'd1,
        STATE_DONE = 2'd2
    } state_t;

    // power_manager register map defaults
    localparam logic [15:0] PM_POWERUP_ADR  = 16'd1;
    localparam logic [15:0] PM_POWERUP_DAT  = 16'd1;
    localparam logic [15:0] PM_RESTART_ADR  = 16'd2;
    localparam logic [15:0] PM_RESTART_DAT  = 16'd0;
    localparam logic [15:0] PM_SHUTDOWN_ADR = 16'd2;
    localparam logic [15:0] PM_SHUTDOWN_DAT = 16'd1;

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : 2-FF synchroniser, counter-based debouncer and edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_async,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]  r_sync;
    logic [31:0] r_cnt;
    logic        r_level;
    logic        r_rise;
    logic        r_fall;
    logic        w_expire;

    assign w_expire = (r_cnt == DEBOUNCE_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= 32'd0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], button_async};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // any agreement with the current level restarts the stability count
            if (r_sync[1] != r_level) begin
                if (w_expire) begin
                    r_level <= r_sync[1];
                    r_cnt   <= 32'd0;
                    r_rise  <= r_sync[1];
                    r_fall  <= ~r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end else begin
                r_cnt <= 32'd0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/power_button_wbm.sv
`default_nettype none
// ============================================================================
// Module      : power_button_wbm
// Description : Classifies debounced power-button presses and issues one
//               single-word Wishbone write to power_manager per press.
// Revision    : 1.0 - initial release
// ============================================================================
module power_button_wbm
    import power_button_wbm_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES   = 32'd50000,
    parameter logic [31:0] LONG_PRESS_CYCLES = 32'd200000000,
    parameter logic [15:0] ACK_TIMEOUT       = 16'd255,
    parameter logic [15:0] POWERUP_ADR       = PM_POWERUP_ADR,
    parameter logic [15:0] RESTART_ADR       = PM_RESTART_ADR,
    parameter logic [15:0] SHUTDOWN_ADR      = PM_SHUTDOWN_ADR
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic        chs_power_button,
    input  logic        power_ok,
    output logic        busy,
    output logic        timeout_err,
    output logic [1:0]  last_cmd
);

    logic        w_level;
    logic        w_rise;
    logic        w_fall;
    logic [31:0] r_press_cnt;
    logic        w_long_evt;
    logic        w_short_evt;
    cmd_t        w_cmd;

    state_t      r_state,    w_state_nxt;
    logic        r_cyc,      w_cyc_nxt;
    logic [15:0] r_adr,      w_adr_nxt;
    logic [15:0] r_dat,      w_dat_nxt;
    logic [15:0] r_tcnt,     w_tcnt_nxt;
    logic        r_err,      w_err_nxt;
    cmd_t        r_last_cmd, w_last_cmd_nxt;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .button_async(chs_power_button),
        .level       (w_level),
        .rise        (w_rise),
        .fall        (w_fall)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_press_cnt <= 32'd0;
        end else if (w_rise) begin
            r_press_cnt <= 32'd0;
        end else if (w_level && (r_press_cnt < LONG_PRESS_CYCLES)) begin
            r_press_cnt <= r_press_cnt + 32'd1;
        end
    end

    // LONG fires in the cycle the counter steps onto the threshold, so it fires once
    assign w_long_evt  = w_level && !w_rise && (r_press_cnt == LONG_PRESS_CYCLES - 32'd1);
    assign w_short_evt = w_fall && (r_press_cnt < LONG_PRESS_CYCLES);

    always_comb begin
        w_cmd = CMD_NONE;
        if (w_short_evt) begin
            w_cmd = power_ok ? CMD_RESTART : CMD_POWERUP;
        end else if (w_long_evt && power_ok) begin
            w_cmd = CMD_SHUTDOWN;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= STATE_IDLE;
            r_cyc      <= 1'b0;
            r_adr      <= 16'd0;
            r_dat      <= 16'd0;
            r_tcnt     <= 16'd0;
            r_err      <= 1'b0;
            r_last_cmd <= CMD_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_adr      <= w_adr_nxt;
            r_dat      <= w_dat_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_err      <= w_err_nxt;
            r_last_cmd <= w_last_cmd_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc;
        w_adr_nxt      = r_adr;
        w_dat_nxt      = r_dat;
        w_tcnt_nxt     = r_tcnt;
        w_err_nxt      = r_err;
        w_last_cmd_nxt = r_last_cmd;
        case (r_state)
            STATE_IDLE: begin
                if (w_cmd != CMD_NONE) begin
                    w_state_nxt    = STATE_REQ;
                    w_cyc_nxt      = 1'b1;
                    w_tcnt_nxt     = 16'd0;
                    w_last_cmd_nxt = w_cmd;
                    case (w_cmd)
                        CMD_POWERUP: begin
                            w_adr_nxt = POWERUP_ADR;
                            w_dat_nxt = PM_POWERUP_DAT;
                        end
                        CMD_RESTART: begin
                            w_adr_nxt = RESTART_ADR;
                            w_dat_nxt = PM_RESTART_DAT;
                        end
                        default: begin
                            w_adr_nxt = SHUTDOWN_ADR;
                            w_dat_nxt = PM_SHUTDOWN_DAT;
                        end
                    endcase
                end
            end
            STATE_REQ: begin
                // ack takes priority over a coincident timeout
                if (wb_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = STATE_DONE;
                end else if (r_tcnt == ACK_TIMEOUT) begin
                    w_cyc_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = STATE_DONE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 16'd1;
                end
            end
            STATE_DONE: begin
                w_state_nxt = STATE_IDLE;
            end
            default: begin
                w_state_nxt = STATE_IDLE;
                w_cyc_nxt   = 1'b0;
            end
        endcase
    end

    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_cyc;
    assign wb_we_o     = r_cyc;
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign busy        = (r_state != STATE_IDLE);
    assign timeout_err = r_err;
    assign last_cmd    = r_last_cmd;

endmodule
`default_nettype wire

// File: tb/tb_power_button_wbm.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_button_wbm
// Description : Self-checking bench for power_button_wbm with a press-level
//               reference model and a simple acking Wishbone slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_button_wbm;

    localparam int DB = 10;
    localparam int LP = 200;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b0;
    logic        pok = 1'b0;
    logic        ack = 1'b0;
    logic        cyc, stb, we, busy, err;
    logic [15:0] adr, dat;
    logic [1:0]  lcmd;

    power_button_wbm #(
        .DEBOUNCE_CYCLES  (32'd10),
        .LONG_PRESS_CYCLES(32'd200),
        .ACK_TIMEOUT      (16'd16)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .wb_cyc_o        (cyc),
        .wb_stb_o        (stb),
        .wb_we_o         (we),
        .wb_adr_o        (adr),
        .wb_dat_o        (dat),
        .wb_ack_i        (ack),
        .chs_power_button(btn),
        .power_ok        (pok),
        .busy            (busy),
        .timeout_err     (err),
        .last_cmd        (lcmd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    bit ack_en = 1'b1;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: synchronised samples, run-length debounce, and
    // press duration measured in debounced-high cycles.
    int          m_s1 = 0, m_s2 = 0, m_lvl = 0, m_run = 0, m_hi = 0, m_fall_h = 0;
    bit          m_fell = 1'b0, m_txn = 1'b0, m_cool = 1'b0;
    int          m_age = 0;
    logic        e_err = 1'b0;
    logic [1:0]  e_last = 2'd0;
    logic [15:0] e_adr = 16'd0, e_dat = 16'd0;

    task automatic model_step();
        int  cmd;
        int  d;
        bit  flipped;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_hi = 0; m_fall_h = 0;
            m_fell = 0; m_txn = 0; m_cool = 0; m_age = 0;
            e_err = 0; e_last = 0; e_adr = 0; e_dat = 0;
        end else begin
            cmd = 0;
            if (m_fell && m_fall_h <= LP)            cmd = pok ? 2 : 1;
            else if (m_lvl == 1 && m_hi == LP + 1 && pok) cmd = 3;
            if (m_txn) begin
                if (ack) begin
                    m_txn = 0; m_cool = 1; e_err = 0;
                end else if (m_age == TO) begin
                    m_txn = 0; m_cool = 1; e_err = 1;
                end else begin
                    m_age++;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if (cmd != 0) begin
                m_txn = 1; m_age = 0; e_last = 2'(cmd);
                case (cmd)
                    1:       begin e_adr = 16'd1; e_dat = 16'd1; end
                    2:       begin e_adr = 16'd2; e_dat = 16'd0; end
                    default: begin e_adr = 16'd2; e_dat = 16'd1; end
                endcase
            end
            d = m_s2; m_s2 = m_s1; m_s1 = int'(btn);
            m_fell = 0; flipped = 0;
            if (d != m_lvl) begin
                m_run++;
                if (m_run == DB) begin
                    m_run = 0; m_lvl = d; flipped = 1;
                    if (d == 1) m_hi = 1;
                    else begin m_fall_h = m_hi; m_fell = 1; m_hi = 0; end
                end
            end else begin
                m_run = 0;
            end
            if (!flipped && m_lvl == 1) m_hi++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc_n++;
        model_step();
    end

    // Slave: acks one cycle after it sees strobe
    initial forever begin
        @(posedge clk);
        #1;
        ack = ack_en && cyc && stb && !ack;
    end

    int txn_count = 0, start_cyc = 0, cur_len = 0, last_len = 0, busy_cycles = 0;
    logic [15:0] last_adr = 0, last_dat = 0;
    bit prev_cyc = 1'b0;

    initial forever begin
        @(negedge clk);
        check("model_cmp",
              {cyc, stb, we, busy, err, lcmd, adr, dat},
              {m_txn, m_txn, m_txn, (m_txn | m_cool), e_err, e_last, e_adr, e_dat});
        if (cyc && !prev_cyc) begin
            txn_count++; start_cyc = cyc_n; last_adr = adr; last_dat = dat; cur_len = 0;
        end
        if (cyc) cur_len++;
        if (!cyc && prev_cyc) last_len = cur_len;
        if (busy) busy_cycles++;
        prev_cyc = cyc;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int hold);
        btn = 1'b1;
        step(hold);
        btn = 1'b0;
    endtask

    task automatic wait_cyc(input int budget, input string name);
        int n = 0;
        while (!cyc && n < budget) begin step(1); n++; end
        check(name, cyc, 1);
    endtask

    task automatic clear_counts();
        txn_count = 0; busy_cycles = 0; last_len = 0;
    endtask

    int p;

    initial begin
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_cyc", cyc, 0);
        check("reset_adr", adr, 0);
        check("reset_last_cmd", lcmd, 0);
        check("reset_err_busy", {err, busy}, 0);
        step(1);

        // short glitches never survive the debouncer
        clear_counts();
        repeat (10) begin btn = 1'b1; step(5); btn = 1'b0; step(5); end
        step(50);
        check("glitch_txn", txn_count, 0);
        check("glitch_last_cmd", lcmd, 0);

        // short press, power off: power-up
        clear_counts(); pok = 1'b0;
        press(50); step(100);
        check("pu_txn", txn_count, 1);
        check("pu_adr_dat", {last_adr, last_dat}, {16'd1, 16'd1});
        check("pu_last_cmd", lcmd, 1);
        check("pu_busy", busy_cycles, 2);

        // short press, power on: restart
        clear_counts(); pok = 1'b1;
        press(50); step(100);
        check("rs_txn", txn_count, 1);
        check("rs_adr_dat", {last_adr, last_dat}, {16'd2, 16'd0});
        check("rs_last_cmd", lcmd, 2);

        // long press, power on: shutdown, nothing on release
        clear_counts(); pok = 1'b1;
        p = cyc_n;
        press(400); step(100);
        check("sd_txn", txn_count, 1);
        check("sd_latency", start_cyc - p, 213);
        check("sd_adr_dat", {last_adr, last_dat}, {16'd2, 16'd1});
        check("sd_last_cmd", lcmd, 3);

        // slave never acks
        clear_counts(); pok = 1'b0; ack_en = 1'b0;
        press(20);
        wait_cyc(100, "to_start");
        begin
            int n = 0;
            while (cyc && n < 50) begin step(1); n++; end
        end
        step(5);
        check("to_len", last_len, 17);
        check("to_err", err, 1);
        check("to_busy", busy_cycles, 18);
        clear_counts(); ack_en = 1'b1;
        press(20); step(100);
        check("to_clear_txn", txn_count, 1);
        check("to_clear_err", err, 0);

        // reset while the request is outstanding
        clear_counts(); ack_en = 1'b0;
        press(20);
        wait_cyc(100, "rst_start");
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_bus", {cyc, stb, we, adr, dat}, 0);
        check("rst_mid_state", {busy, err, lcmd}, 0);
        step(1);
        txn_count = 0;
        step(60);
        check("rst_no_reissue", txn_count, 0);
        ack_en = 1'b1; pok = 1'b0;
        press(20); step(100);
        check("rst_after_txn", txn_count, 1);
        check("rst_after_cmd", lcmd, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
